// File: rtl/cfg_flash_spi_master.sv
// SPI mode-0 master for the FPGA configuration flash: divided clock driven through
// the vendor master-clock primitive (mclk/mclk_ts), byte-stream valid/ready payload.
module cfg_flash_spi_master #(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned DIV_W         = 8,
  parameter int unsigned LEN_W         = 16,
  parameter bit          IDLE_TRISTATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] xfer_len,
  output logic             busy,
  output logic             done,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             mclk,
  output logic             mclk_ts,
  output logic             flash_cs_n,
  output logic             flash_mosi,
  input  logic             flash_miso
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_FETCH,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       tx_sh_q, tx_sh_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tx_ready_q, tx_ready_d;
  logic             mclk_q, mclk_d;
  logic             mclk_ts_q, mclk_ts_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;

  logic             tick;
  logic             sample;
  logic [7:0]       rx_full;

  assign tick    = (div_q == DIV_W'(CLK_DIV - 1));
  // MISO is captured on the cycle right after mclk rises
  assign sample  = (state_q == S_SHIFT_HI) && (div_q == '0);
  assign rx_full = sample ? {rx_sh_q[6:0], flash_miso} : rx_sh_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      len_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      mclk_q     <= 1'b0;
      mclk_ts_q  <= IDLE_TRISTATE;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      len_q      <= len_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_ready_q <= tx_ready_d;
      mclk_q     <= mclk_d;
      mclk_ts_q  <= mclk_ts_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = '0;
    len_d      = len_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_full;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    mosi_d     = mosi_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (xfer_len != '0) begin
            len_d   = xfer_len;
            state_d = S_SETUP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (tick) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (tx_valid && tx_ready_q) begin
          tx_sh_d = tx_data[6:0];
          mosi_d  = tx_data[7];
          bit_d   = '0;
          state_d = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        if (tick) state_d = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        if (tick) begin
          if (bit_q != 3'd7) begin
            bit_d   = 3'(bit_q + 3'd1);
            mosi_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[5:0], 1'b0};
            state_d = S_SHIFT_LO;
          end else begin
            rx_data_d  = rx_full;
            rx_valid_d = 1'b1;
            len_d      = LEN_W'(len_q - LEN_W'(1));
            state_d    = (len_q == LEN_W'(1)) ? S_HOLD : S_FETCH;
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Divider restarts on every state entry; it only runs in timed states
    if ((state_d == state_q) &&
        (state_q inside {S_SETUP, S_SHIFT_LO, S_SHIFT_HI, S_HOLD})) begin
      div_d = DIV_W'(div_q + DIV_W'(1));
    end

    busy_d     = (state_d != S_IDLE);
    cs_n_d     = (state_d == S_IDLE);
    mclk_ts_d  = (state_d == S_IDLE) ? IDLE_TRISTATE : 1'b0;
    mclk_d     = (state_d == S_SHIFT_HI);
    tx_ready_d = (state_d == S_FETCH);
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign tx_ready   = tx_ready_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign mclk       = mclk_q;
  assign mclk_ts    = mclk_ts_q;
  assign flash_cs_n = cs_n_q;
  assign flash_mosi = mosi_q;

endmodule

// File: tb/tb_cfg_flash_spi_master.sv
// Bench for cfg_flash_spi_master: three instances (CLK_DIV 1/2/5), a waveform model built
// from phase durations, a reactive mode-0 flash slave, and literal pins on key counts.
`timescale 1ns/1ps
module tb_cfg_flash_spi_master;

  localparam int unsigned NDUT  = 3;
  localparam int unsigned LEN_W = 16;

  typedef struct packed {
    logic       busy;
    logic       cs_n;
    logic       ts;
    logic       mclk;
    logic       mosi;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       done;
  } obs_t;

  typedef struct packed {
    logic             start;
    logic [LEN_W-1:0] len;
    logic             tx_valid;
    logic [7:0]       tx_data;
  } stim_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [NDUT-1:0] start_a, tx_valid_a;
  logic [NDUT-1:0] busy_a, done_a, tx_ready_a, rx_valid_a, mclk_a, mclk_ts_a, cs_n_a, mosi_a;
  logic [LEN_W-1:0] len_a [NDUT];
  logic [7:0]       tx_data_a [NDUT];
  logic [7:0]       rx_data_a [NDUT];
  logic miso = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    cfg_flash_spi_master #(
      .CLK_DIV      ((g == 0) ? 1 : ((g == 1) ? 2 : 5)),
      .DIV_W        (8),
      .LEN_W        (LEN_W),
      .IDLE_TRISTATE(g != 2)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start_a[g]),
      .xfer_len  (len_a[g]),
      .busy      (busy_a[g]),
      .done      (done_a[g]),
      .tx_data   (tx_data_a[g]),
      .tx_valid  (tx_valid_a[g]),
      .tx_ready  (tx_ready_a[g]),
      .rx_data   (rx_data_a[g]),
      .rx_valid  (rx_valid_a[g]),
      .mclk      (mclk_a[g]),
      .mclk_ts   (mclk_ts_a[g]),
      .flash_cs_n(cs_n_a[g]),
      .flash_mosi(mosi_a[g]),
      .flash_miso(miso)
    );
  end

  // Model state and scenario data
  int         sel = 1;
  logic [7:0] m_rx [NDUT];
  logic       rxv_pend;
  obs_t       exp_q[$];
  stim_t      stim_q[$];
  logic [7:0] g_tx[$];
  logic [7:0] g_rx[$];
  int         g_gap[$];

  int n_chk = 0, n_pass = 0;
  int cs_low, rxv_cnt, done_cnt, hs_cnt, busy_cnt;

  function automatic int div_of(int s);
    return (s == 0) ? 1 : ((s == 1) ? 2 : 5);
  endfunction

  function automatic logic it_of(int s);
    return (s != 2);
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.cs_n    = 1'b1;
    o.ts      = it_of(sel);
    o.rx_data = m_rx[sel];
    return o;
  endfunction

  function automatic void push(obs_t o, stim_t s);
    obs_t t;
    t = o;
    t.rx_valid = rxv_pend;
    rxv_pend = 1'b0;
    exp_q.push_back(t);
    stim_q.push_back(s);
  endfunction

  // Expected waveform: setup half-period, per byte (fetch wait + 8 low/high phase pairs), hold.
  function automatic void push_xfer();
    int    d;
    obs_t  o;
    stim_t s0, s;
    d  = div_of(sel);
    s0 = '0;
    s  = '0;
    s.start = 1'b1;
    s.len   = LEN_W'(g_tx.size());
    push(idle_obs(), s);
    o = idle_obs();
    o.busy = 1'b1;
    o.cs_n = 1'b0;
    o.ts   = 1'b0;
    for (int i = 0; i < d; i++) push(o, s0);
    for (int k = 0; k < g_tx.size(); k++) begin
      o.tx_ready = 1'b1;
      for (int w = 0; w < g_gap[k]; w++) push(o, s0);
      s = '0;
      s.tx_valid = 1'b1;
      s.tx_data  = g_tx[k];
      push(o, s);
      o.tx_ready = 1'b0;
      for (int b = 7; b >= 0; b--) begin
        o.mosi = g_tx[k][b];
        o.mclk = 1'b0;
        for (int i = 0; i < d; i++) push(o, s0);
        o.mclk = 1'b1;
        for (int i = 0; i < d; i++) push(o, s0);
      end
      o.mclk    = 1'b0;
      o.rx_data = g_rx[k];
      rxv_pend  = 1'b1;
    end
    for (int i = 0; i < d; i++) push(o, s0);
    m_rx[sel] = o.rx_data;
    o = idle_obs();
    o.done = 1'b1;
    push(o, s0);
  endfunction

  function automatic void push_zero_len();
    obs_t  o;
    stim_t s;
    s = '0;
    s.start = 1'b1;
    push(idle_obs(), s);
    o = idle_obs();
    o.done = 1'b1;
    push(o, '0);
  endfunction

  function automatic obs_t get_obs(int s);
    obs_t a;
    a.busy     = busy_a[s];
    a.cs_n     = cs_n_a[s];
    a.ts       = mclk_ts_a[s];
    a.mclk     = mclk_a[s];
    a.mosi     = mosi_a[s];
    a.tx_ready = tx_ready_a[s];
    a.rx_valid = rx_valid_a[s];
    a.rx_data  = rx_data_a[s];
    a.done     = done_a[s];
    return a;
  endfunction

  task automatic chk_obs(input string nm, input obs_t a, input obs_t e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s dut%0d t=%0t got busy=%b cs_n=%b ts=%b mclk=%b mosi=%b txr=%b rxv=%b rx=%h done=%b want busy=%b cs_n=%b ts=%b mclk=%b mosi=%b txr=%b rxv=%b rx=%h done=%b",
                  nm, sel, $time, a.busy, a.cs_n, a.ts, a.mclk, a.mosi, a.tx_ready, a.rx_valid, a.rx_data, a.done,
                  e.busy, e.cs_n, e.ts, e.mclk, e.mosi, e.tx_ready, e.rx_valid, e.rx_data, e.done);
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s dut%0d got %0d want %0d", nm, sel, got, want);
  endtask

  // One cycle: compare at the falling edge, then drive the next stimulus
  task automatic step();
    obs_t  e, a;
    stim_t s;
    @(negedge clk);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = idle_obs();
    a = get_obs(sel);
    chk_obs("cycle", a, e);
    if (!a.cs_n)    cs_low++;
    if (a.rx_valid) rxv_cnt++;
    if (a.done)     done_cnt++;
    if (a.busy)     busy_cnt++;
    if (stim_q.size() != 0) s = stim_q.pop_front();
    else s = '0;
    if (s.tx_valid && a.tx_ready) hs_cnt++;
    start_a[sel]    = s.start;
    len_a[sel]      = s.len;
    tx_valid_a[sel] = s.tx_valid;
    tx_data_a[sel]  = s.tx_data;
  endtask

  task automatic prep(input int s);
    sel      = s;
    cs_low   = 0;
    rxv_cnt  = 0;
    done_cnt = 0;
    hs_cnt   = 0;
    busy_cnt = 0;
    g_tx.delete();
    g_rx.delete();
    g_gap.delete();
  endtask

  task automatic run_out();
    while (exp_q.size() != 0) step();
    repeat (3) step();
  endtask

  // Flash slave (mode 0): shifts MISO on falling mclk, captures MOSI on rising mclk
  logic a_mclk, a_cs_n, a_mosi;
  assign a_mclk = mclk_a[sel];
  assign a_cs_n = cs_n_a[sel];
  assign a_mosi = mosi_a[sel];

  logic sl_mclk_l = 1'b0;
  logic sl_cs_l   = 1'b1;
  logic cap_bits[$];
  time  rise_t[$];

  function automatic logic miso_bit(int i);
    logic [7:0] b;
    if (i / 8 < g_rx.size()) begin
      b = g_rx[i / 8];
      return b[7 - (i % 8)];
    end
    return 1'b0;
  endfunction

  always @(a_mclk or a_cs_n) begin
    if (sl_cs_l === 1'b1 && a_cs_n === 1'b0) begin
      cap_bits.delete();
      rise_t.delete();
      miso = miso_bit(0);
    end
    if (sl_mclk_l === 1'b0 && a_mclk === 1'b1 && a_cs_n === 1'b0) begin
      cap_bits.push_back(a_mosi);
      rise_t.push_back($time);
    end
    if (sl_mclk_l === 1'b1 && a_mclk === 1'b0) miso = miso_bit(cap_bits.size());
    sl_mclk_l = a_mclk;
    sl_cs_l   = a_cs_n;
  end

  task automatic chk_caps();
    logic [7:0] b;
    for (int k = 0; k < g_tx.size(); k++) begin
      b = '0;
      for (int i = 0; i < 8; i++)
        if (8 * k + i < cap_bits.size()) b = {b[6:0], cap_bits[8 * k + i]};
      chk_int($sformatf("mosi_byte%0d", k), int'(b), int'(g_tx[k]));
    end
  endtask

  task automatic chk_period(input int want);
    if (rise_t.size() < 2) chk_int("mclk_period", -1, want);
    else chk_int("mclk_period", int'(rise_t[1] - rise_t[0]), want);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t e;
    start_a    = '0;
    tx_valid_a = '0;
    rxv_pend   = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      len_a[i]     = '0;
      tx_data_a[i] = '0;
      m_rx[i]      = '0;
    end

    // Reset state of every instance
    #1 reset_n = 1'b0;
    #2;
    for (int s = 0; s < NDUT; s++) begin
      sel = s;
      e = '0;
      e.cs_n = 1'b1;
      e.ts   = (s != 2);
      chk_obs("reset_state", get_obs(s), e);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single byte at CLK_DIV=2: tx A5, flash returns 3C
    prep(1);
    g_tx.push_back(8'hA5); g_rx.push_back(8'h3C); g_gap.push_back(0);
    push_xfer();
    run_out();
    chk_int("t1_cs_low", cs_low, 37);
    chk_int("t1_rises", cap_bits.size(), 8);
    chk_int("t1_rx_valid", rxv_cnt, 1);
    chk_int("t1_done", done_cnt, 1);
    chk_int("t1_rx_data", int'(rx_data_a[1]), 8'h3C);
    chk_period(40);
    chk_caps();

    // Read command + address, two dummy bytes; a stray start mid-transfer
    prep(1);
    g_tx.push_back(8'h03); g_tx.push_back(8'hA2); g_tx.push_back(8'hA1);
    g_tx.push_back(8'hA0); g_tx.push_back(8'h00); g_tx.push_back(8'h00);
    g_rx.push_back(8'hFF); g_rx.push_back(8'hFF); g_rx.push_back(8'hFF);
    g_rx.push_back(8'hFF); g_rx.push_back(8'h5A); g_rx.push_back(8'hC3);
    for (int k = 0; k < 6; k++) g_gap.push_back(0);
    push_xfer();
    stim_q[60].start = 1'b1;
    stim_q[60].len   = LEN_W'(3);
    run_out();
    chk_int("t2_handshakes", hs_cnt, 6);
    chk_int("t2_rx_valid", rxv_cnt, 6);
    chk_int("t2_rises", cap_bits.size(), 48);
    chk_int("t2_cs_low", cs_low, 202);
    chk_int("t2_done", done_cnt, 1);
    chk_int("t2_rx_data", int'(rx_data_a[1]), 8'hC3);
    chk_caps();

    // tx_valid withheld 20 cycles before byte 2
    prep(1);
    g_tx.push_back(8'h9C); g_tx.push_back(8'h41); g_tx.push_back(8'hE7);
    g_rx.push_back(8'h12); g_rx.push_back(8'h34); g_rx.push_back(8'h56);
    g_gap.push_back(0); g_gap.push_back(20); g_gap.push_back(0);
    push_xfer();
    run_out();
    chk_int("t3_cs_low", cs_low, 123);
    chk_int("t3_rises", cap_bits.size(), 24);
    chk_int("t3_rx_data", int'(rx_data_a[1]), 8'h56);
    chk_caps();

    // Zero-length start
    prep(1);
    push_zero_len();
    run_out();
    chk_int("t4_done", done_cnt, 1);
    chk_int("t4_cs_low", cs_low, 0);
    chk_int("t4_busy", busy_cnt, 0);

    // Asynchronous reset in the middle of the first byte
    prep(1);
    g_tx.push_back(8'hF0); g_tx.push_back(8'h0F);
    g_rx.push_back(8'hAA); g_rx.push_back(8'h55);
    g_gap.push_back(0); g_gap.push_back(0);
    push_xfer();
    for (int i = 0; i < 12; i++) step();
    #2 reset_n = 1'b0;
    #1;
    e = '0;
    e.cs_n = 1'b1;
    e.ts   = 1'b1;
    chk_obs("t5_async_reset", get_obs(1), e);
    exp_q.delete();
    stim_q.delete();
    start_a    = '0;
    tx_valid_a = '0;
    rxv_pend   = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      m_rx[i]      = '0;
      len_a[i]     = '0;
      tx_data_a[i] = '0;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Normal transfer after the reset
    prep(1);
    g_tx.push_back(8'hC3); g_tx.push_back(8'h5A);
    g_rx.push_back(8'h81); g_rx.push_back(8'h7E);
    g_gap.push_back(0); g_gap.push_back(0);
    push_xfer();
    run_out();
    chk_int("t6_rises", cap_bits.size(), 16);
    chk_int("t6_rx_data", int'(rx_data_a[1]), 8'h7E);
    chk_caps();

    // CLK_DIV=1
    prep(0);
    g_tx.push_back(8'hA5); g_tx.push_back(8'h3C); g_tx.push_back(8'hFF);
    g_rx.push_back(8'h0F); g_rx.push_back(8'hF0); g_rx.push_back(8'h99);
    g_gap.push_back(0); g_gap.push_back(2); g_gap.push_back(0);
    push_xfer();
    run_out();
    chk_period(20);
    chk_int("t7_rises", cap_bits.size(), 24);
    chk_int("t7_cs_low", cs_low, 55);
    chk_int("t7_rx_data", int'(rx_data_a[0]), 8'h99);
    chk_caps();

    // CLK_DIV=5, clock driven low when idle
    prep(2);
    g_tx.push_back(8'h6B); g_tx.push_back(8'hD2);
    g_rx.push_back(8'hE1); g_rx.push_back(8'h1E);
    g_gap.push_back(3); g_gap.push_back(0);
    push_xfer();
    run_out();
    chk_period(100);
    chk_int("t8_rises", cap_bits.size(), 16);
    chk_int("t8_cs_low", cs_low, 175);
    chk_int("t8_rx_data", int'(rx_data_a[2]), 8'h1E);
    chk_caps();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
